// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver on a shared oversampling baud tick
// Optional stop-bit checking is enabled by defining RX_FRAME_ERR_EN.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_rate,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] d_out,
  output logic                 rx_done,
  output logic                 frame_err
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [1:0]           sync;
  logic                 rx_s;
  logic                 armed;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 start_pt;
  logic                 bit_pt;
  logic                 last_bit;
  logic                 done_set;

  assign rx_s     = sync[1];
  // The start tick T0 is itself the first start-bit tick, so mid-bit lands one count early.
  assign start_pt = (tick_cnt == TW'(OVERSAMPLE / 2 - 2));
  assign bit_pt   = (tick_cnt == TW'(OVERSAMPLE - 1));
  assign last_bit = (bit_cnt == BW'(DATA_BITS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (baud_rate && armed && !rx_s) state_nxt = START;
      START:   if (baud_rate && start_pt) state_nxt = rx_s ? IDLE : DATA;
      DATA:    if (baud_rate && bit_pt && last_bit) state_nxt = STOP;
      STOP:    if (baud_rate && bit_pt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef RX_FRAME_ERR_EN
  logic err_set;

  always_comb begin
    done_set = 1'b0;
    err_set  = 1'b0;
    if (state == STOP && baud_rate && bit_pt) begin
      done_set = rx_s;
      err_set  = !rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) frame_err <= 1'b0;
    else      frame_err <= err_set;
  end
`else
  always_comb begin
    done_set = 1'b0;
    if (state == STOP && baud_rate && bit_pt) done_set = 1'b1;
  end

  assign frame_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync     <= 2'b11;
      armed    <= 1'b0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      d_out    <= '0;
      rx_done  <= 1'b0;
    end else begin
      sync    <= {sync[0], rx};
      rx_done <= done_set;
      if (done_set) d_out <= shift;
      case (state)
        IDLE: begin
          if (rx_s) armed <= 1'b1;
          if (baud_rate && armed && !rx_s) tick_cnt <= '0;
        end
        START: if (baud_rate) begin
          if (start_pt) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        DATA: if (baud_rate) begin
          if (bit_pt) begin
            shift    <= {rx_s, shift[DATA_BITS-1:1]};
            tick_cnt <= '0;
            bit_cnt  <= bit_cnt + 1'b1;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        STOP: if (baud_rate) begin
          if (bit_pt) begin
            tick_cnt <= '0;
            // A low stop bit leaves the receiver disarmed until the line idles high.
            armed    <= rx_s;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx
// Frame timing is described in baud ticks; the model predicts each event's value and tick.
module tb_uart_rx;

  logic       clk;
  logic       rst;
  logic       baud_rate;
  logic       rx;
  logic [7:0] d_out;
  logic       rx_done;
  logic       frame_err;

  typedef struct {
    int kind;
    int val;
    int tick;
  } evt_t;

  evt_t exp_q[$];
  evt_t obs_q[$];
  int   tick_count = 0;
  int   checks = 0;
  int   errors = 0;
  int   overlap = 0;
  logic [7:0] exp_d = 8'h00;

  uart_rx dut (
    .clk       (clk),
    .rst       (rst),
    .baud_rate (baud_rate),
    .rx        (rx),
    .d_out     (d_out),
    .rx_done   (rx_done),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-clk tick every 4 clks.
  initial begin
    baud_rate = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 baud_rate = 1'b1;
      @(posedge clk);
      #1 baud_rate = 1'b0;
    end
  end

  always @(posedge clk) if (baud_rate) tick_count <= tick_count + 1;

  always @(negedge clk) begin
    if (rst) begin
      if (rx_done)   obs_q.push_back('{0, int'(d_out), tick_count});
      if (frame_err) obs_q.push_back('{1, int'(d_out), tick_count});
      if (rx_done && frame_err) overlap++;
    end
  end

  task automatic check(input string tag, input int got, input int expected);
    checks++;
    if (got !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expected);
    end
  endtask

  task automatic wait_tick();
    do @(posedge clk); while (baud_rate !== 1'b1);
    #2;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) wait_tick();
  endtask

  // Drives one frame starting right after the current tick; abort_at >= 0 stops early.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int abort_at);
    int d;
    d = tick_count;
    for (int t = 0; t < 160; t++) begin
      if (t == abort_at) return;
      if (t < 16)       rx = 1'b0;
      else if (t < 144) rx = b[(t - 16) / 16];
      else              rx = stop_v;
      wait_tick();
    end
`ifdef RX_FRAME_ERR_EN
    if (stop_v) begin
      exp_q.push_back('{0, int'(b), d + 152});
      exp_d = b;
    end else begin
      exp_q.push_back('{1, int'(exp_d), d + 152});
    end
`else
    exp_q.push_back('{0, int'(b), d + 152});
    exp_d = b;
`endif
  endtask

  task automatic verify(input string tag);
    int n;
    check({tag, "_evt_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_kind"}, obs_q[i].kind, exp_q[i].kind);
      check({tag, "_val"},  obs_q[i].val,  exp_q[i].val);
      check({tag, "_tick"}, obs_q[i].tick, exp_q[i].tick);
    end
    obs_q.delete();
    exp_q.delete();
    check({tag, "_d_out"}, int'(d_out), int'(exp_d));
  endtask

  initial begin
    int gap;
    logic [7:0] b;
    logic sv;
    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_d_out", int'(d_out), 0);
    check("rst_rx_done", int'(rx_done), 0);
    check("rst_frame_err", int'(frame_err), 0);
    rst = 1'b1;
    wait_tick();
    idle(5);

    send_frame(8'hA5, 1'b1, -1);
    idle(10);
    verify("a5");

    rx = 1'b0;
    repeat (4) wait_tick();
    idle(20);
    verify("glitch");

    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    idle(5);
    verify("b2b");

    send_frame(8'h3C, 1'b0, -1);
    rx = 1'b0;
    repeat (640) wait_tick();
    idle(10);
    verify("bad_stop_break");
    send_frame(8'h5A, 1'b1, -1);
    idle(5);
    verify("after_break");

    send_frame(8'h81, 1'b1, 80);
    rst = 1'b0;
    #1;
    check("midrst_d_out", int'(d_out), 0);
    check("midrst_rx_done", int'(rx_done), 0);
    check("midrst_frame_err", int'(frame_err), 0);
    rx = 1'b1;
    exp_d = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    wait_tick();
    idle(10);
    verify("midrst_quiet");
    send_frame(8'h81, 1'b1, -1);
    idle(5);
    verify("after_rst");

    for (int i = 0; i < 8; i++) begin
      b  = 8'($urandom);
      sv = ($urandom_range(0, 3) != 0);
      send_frame(b, sv, -1);
      gap = sv ? int'($urandom_range(0, 12)) : int'($urandom_range(1, 12));
      idle(gap);
      verify("rand");
    end

    check("done_err_overlap", overlap, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
